// File: rtl/rx_cmd_sequencer.sv
// RX FIFO command decoder: parses OP/ADDR/LEN/payload packets into buffer writes and core starts.
// Optional trailing XOR checksum byte is enabled by defining RX_CHECKSUM_EN.
module rx_cmd_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_re,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  wbuf_we,
  output logic                  abuf_we,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  output logic [DATA_WIDTH-1:0] buf_wdata,
  input  logic                  core_busy,
  output logic                  core_start,
  output logic                  cmd_done,
  output logic                  cmd_err
);

  typedef enum logic [2:0] {
    S_OP,
    S_ADDR,
    S_LEN,
    S_DATA,
`ifdef RX_CHECKSUM_EN
    S_CSUM,
`endif
    S_RUN
  } state_t;

  state_t                state_q, state_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  byte_vld_q, byte_vld_d;
  logic [DATA_WIDTH-1:0] byte_q, byte_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic                  is_w_q, is_w_d;
  logic                  wbuf_we_q, wbuf_we_d;
  logic                  abuf_we_q, abuf_we_d;
  logic [ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_WIDTH-1:0] buf_wdata_q, buf_wdata_d;
  logic                  core_start_q, core_start_d;
  logic                  cmd_done_q, cmd_done_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  pkt_end;
`ifdef RX_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

  always_comb begin
    state_d      = state_q;
    rd_pend_d    = fifo_re;
    byte_vld_d   = rd_pend_q;
    byte_d       = rd_pend_q ? fifo_r_data : byte_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    is_w_d       = is_w_q;
    wbuf_we_d    = 1'b0;
    abuf_we_d    = 1'b0;
    buf_addr_d   = buf_addr_q;
    buf_wdata_d  = buf_wdata_q;
    core_start_d = 1'b0;
    cmd_done_d   = 1'b0;
    cmd_err_d    = 1'b0;
    pkt_end      = 1'b0;
`ifdef RX_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    case (state_q)
      S_OP: if (byte_vld_q) begin
        if (byte_q == DATA_WIDTH'(1)) begin
          is_w_d  = 1'b1;
          state_d = S_ADDR;
        end else if (byte_q == DATA_WIDTH'(2)) begin
          is_w_d  = 1'b0;
          state_d = S_ADDR;
        end else if (byte_q == DATA_WIDTH'(3)) begin
          state_d = S_RUN;
        end else begin
          cmd_err_d = 1'b1;
        end
      end
      S_ADDR: if (byte_vld_q) begin
        addr_d  = ADDR_WIDTH'(byte_q);
        state_d = S_LEN;
      end
      S_LEN: if (byte_vld_q) begin
        cnt_d   = byte_q;
        state_d = S_DATA;
        if (byte_q == '0) pkt_end = 1'b1;
      end
      S_DATA: if (byte_vld_q) begin
        wbuf_we_d   = is_w_q;
        abuf_we_d   = !is_w_q;
        buf_addr_d  = addr_q;
        buf_wdata_d = byte_q;
        addr_d      = addr_q + ADDR_WIDTH'(1);
        cnt_d       = cnt_q - DATA_WIDTH'(1);
        if (cnt_q == DATA_WIDTH'(1)) pkt_end = 1'b1;
      end
`ifdef RX_CHECKSUM_EN
      S_CSUM: if (byte_vld_q) begin
        cmd_done_d = (byte_q == csum_q);
        cmd_err_d  = (byte_q != csum_q);
        state_d    = S_OP;
      end
`endif
      S_RUN: if (!core_busy) begin
        core_start_d = 1'b1;
        cmd_done_d   = 1'b1;
        state_d      = S_OP;
      end
      default: state_d = S_OP;
    endcase

    if (pkt_end) begin
`ifdef RX_CHECKSUM_EN
      state_d = S_CSUM;
`else
      cmd_done_d = 1'b1;
      state_d    = S_OP;
`endif
    end

`ifdef RX_CHECKSUM_EN
    // XOR restarts on the opcode byte so each packet is checked independently.
    if (byte_vld_q) begin
      if (state_q == S_OP) csum_d = byte_q;
      else if (state_q != S_CSUM) csum_d = csum_q ^ byte_q;
    end
`endif
  end

  // Issue a read only when idle on the FIFO and the next state will consume a byte.
  assign fifo_re = !rst && !fifo_empty && !rd_pend_q && (state_d != S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_OP;
      rd_pend_q    <= 1'b0;
      byte_vld_q   <= 1'b0;
      byte_q       <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      is_w_q       <= 1'b0;
      wbuf_we_q    <= 1'b0;
      abuf_we_q    <= 1'b0;
      buf_addr_q   <= '0;
      buf_wdata_q  <= '0;
      core_start_q <= 1'b0;
      cmd_done_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
`ifdef RX_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rd_pend_q    <= rd_pend_d;
      byte_vld_q   <= byte_vld_d;
      byte_q       <= byte_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      is_w_q       <= is_w_d;
      wbuf_we_q    <= wbuf_we_d;
      abuf_we_q    <= abuf_we_d;
      buf_addr_q   <= buf_addr_d;
      buf_wdata_q  <= buf_wdata_d;
      core_start_q <= core_start_d;
      cmd_done_q   <= cmd_done_d;
      cmd_err_q    <= cmd_err_d;
`ifdef RX_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign wbuf_we    = wbuf_we_q;
  assign abuf_we    = abuf_we_q;
  assign buf_addr   = buf_addr_q;
  assign buf_wdata  = buf_wdata_q;
  assign core_start = core_start_q;
  assign cmd_done   = cmd_done_q;
  assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_rx_cmd_sequencer.sv
// Scoreboard bench for rx_cmd_sequencer; honours RX_CHECKSUM_EN when defined.
module tb_rx_cmd_sequencer;
`ifdef RX_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty;
  logic       fifo_re;
  logic [7:0] fifo_r_data = '0;
  logic       wbuf_we, abuf_we, core_start, cmd_done, cmd_err;
  logic [7:0] buf_addr, buf_wdata;
  logic       core_busy = 1'b0;

  rx_cmd_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_re(fifo_re),
    .fifo_r_data(fifo_r_data), .wbuf_we(wbuf_we), .abuf_we(abuf_we),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata), .core_busy(core_busy),
    .core_start(core_start), .cmd_done(cmd_done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // RX FIFO model with registered read data
  logic [7:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_re && (wr_ptr != rd_ptr)) begin
      fifo_r_data <= mem[rd_ptr & 255];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  // flags: {we_w, we_a, start, done, err}
  typedef struct packed {
    logic [4:0] fl;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;
  ev_t exp_q[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  logic to_flag = 1'b0;
  logic fin_flag = 1'b0;
  logic [7:0] xor_acc;

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr & 255] = b;
    wr_ptr  = wr_ptr + 1;
    xor_acc = xor_acc ^ b;
  endtask

  task automatic exp_ev(input logic [4:0] fl, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.fl = fl; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // LOAD packet with up to 3 payload bytes; trailing checksum appended when enabled
  task automatic send_load(input logic [7:0] op, input logic [7:0] addr, input int n,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] pl [3];
    logic [4:0] wfl;
    pl[0] = b0; pl[1] = b1; pl[2] = b2;
    wfl = (op == 8'h01) ? 5'b10000 : 5'b01000;
    xor_acc = '0;
    push_byte(op); push_byte(addr); push_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      push_byte(pl[i]);
      exp_ev(wfl | ((i == n - 1 && !CSUM) ? 5'b00010 : 5'b00000), addr + 8'(i), pl[i]);
    end
    if (n == 0 && !CSUM) exp_ev(5'b00010, '0, '0);
    if (CSUM) begin
      push_byte(xor_acc);
      exp_ev(5'b00010, '0, '0);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || !fifo_empty) && k < 400) begin
      cyc(1);
      k++;
    end
    if (k >= 400) begin
      to_flag = 1'b1;
      cyc(1);
      to_flag = 1'b0;
    end
    cyc(4);
  endtask

  task automatic chk(input string name, input logic ok, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: sole owner of the comparison counters
  initial begin : monitor
    logic prev_rst, prev_busy;
    ev_t  obs, e;
    prev_rst = 1'b0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (prev_rst)
          chk("reset_outputs",
              {fifo_re, wbuf_we, abuf_we, core_start, cmd_done, cmd_err, buf_addr, buf_wdata} == '0,
              32'({fifo_re, wbuf_we, abuf_we, core_start, cmd_done, cmd_err, buf_addr, buf_wdata}), 32'h0);
      end else begin
        if (fifo_re) chk("fifo_re_while_empty", !fifo_empty, 32'(fifo_empty), 32'h0);
        if (core_start) chk("start_while_busy", !prev_busy, 32'(prev_busy), 32'h0);
        obs.fl = {wbuf_we, abuf_we, core_start, cmd_done, cmd_err};
        obs.addr = (wbuf_we || abuf_we) ? buf_addr : 8'h00;
        obs.data = (wbuf_we || abuf_we) ? buf_wdata : 8'h00;
        if (obs.fl != '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_event", 1'b0, 32'(obs), 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("event", obs == e, 32'(obs), 32'(e));
          end
        end
      end
      if (to_flag) chk("drain_timeout", 1'b0, 32'(exp_q.size()), 32'h0);
      if (fin_flag) chk("queue_empty_at_end", exp_q.size() == 0, 32'(exp_q.size()), 32'h0);
      prev_rst  = rst;
      prev_busy = core_busy;
    end
  end

  initial begin
    xor_acc = '0;
    cyc(4);
    rst = 1'b0;
    cyc(2);

    // 1: LOAD_W three bytes
    send_load(8'h01, 8'h10, 3, 8'hAA, 8'hBB, 8'hCC);
    drain();
    // 2: LOAD_A with address wrap
    send_load(8'h02, 8'hFE, 3, 8'h11, 8'h22, 8'h33);
    drain();
    // 3: RUN held off by core_busy
    core_busy = 1'b1;
    xor_acc = '0;
    push_byte(8'h03);
    exp_ev(5'b00110, '0, '0);
    cyc(8);
    core_busy = 1'b0;
    drain();
    // RUN with core idle, then a single-byte LOAD_A
    push_byte(8'h03);
    exp_ev(5'b00110, '0, '0);
    drain();
    send_load(8'h02, 8'h80, 1, 8'hC3, 8'h00, 8'h00);
    drain();
    // 4: bad opcode then zero-length LOAD
    push_byte(8'h7F);
    exp_ev(5'b00001, '0, '0);
    send_load(8'h01, 8'h00, 0, 8'h00, 8'h00, 8'h00);
    drain();
    // 5: FIFO starves mid-payload
    xor_acc = '0;
    push_byte(8'h01); push_byte(8'h20); push_byte(8'h02); push_byte(8'h55);
    exp_ev(5'b10000, 8'h20, 8'h55);
    cyc(30);
    push_byte(8'h66);
    exp_ev(CSUM ? 5'b10000 : 5'b10010, 8'h21, 8'h66);
    if (CSUM) begin
      push_byte(xor_acc);
      exp_ev(5'b00010, '0, '0);
    end
    drain();
    // 6: reset mid-payload abandons packet; next byte is an opcode
    xor_acc = '0;
    push_byte(8'h01); push_byte(8'h40); push_byte(8'h04); push_byte(8'h11); push_byte(8'h22);
    exp_ev(5'b10000, 8'h40, 8'h11);
    exp_ev(5'b10000, 8'h41, 8'h22);
    drain();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    send_load(8'h02, 8'h50, 1, 8'h77, 8'h00, 8'h00);
    drain();
    if (CSUM) begin
      // Checksum match and mismatch
      xor_acc = '0;
      push_byte(8'h01); push_byte(8'h00); push_byte(8'h01); push_byte(8'h5A); push_byte(8'h5A);
      exp_ev(5'b10000, 8'h00, 8'h5A);
      exp_ev(5'b00010, '0, '0);
      drain();
      push_byte(8'h01); push_byte(8'h00); push_byte(8'h01); push_byte(8'h5A); push_byte(8'h00);
      exp_ev(5'b10000, 8'h00, 8'h5A);
      exp_ev(5'b00001, '0, '0);
      drain();
    end

    fin_flag = 1'b1;
    cyc(1);
    fin_flag = 1'b0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
